// File: rtl/mul_add_tree_pkg.sv
// Shared constants for the pipelined shift-and-add multiplier.
// LAT counts the operand register plus one register per adder-tree level.
package mul_add_tree_pkg;

  localparam int DEFAULT_WIDTH = 4;

  function automatic int calc_lat(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/mul_add_tree_level.sv
// One registered adder-tree level: sums adjacent input pairs, N_IN -> N_IN/2 words.
// Latency 1 enabled cycle; no backpressure, the level advances whenever ena is high.
// Valid rides alongside the data and is cleared by reset.
module mul_add_tree_level #(
  parameter int N_IN  = 2,
  parameter int WIDTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ena,
  input  logic                            in_valid,
  input  logic [N_IN*2*WIDTH-1:0]         in_dat,
  output logic                            out_valid,
  output logic [(N_IN/2)*2*WIDTH-1:0]     out_dat
);

  localparam int PW    = 2 * WIDTH;
  localparam int N_OUT = N_IN / 2;

  logic [N_OUT*PW-1:0] sum;

  always_comb begin
    sum = '0;
    for (int j = 0; j < N_OUT; j++) begin
      sum[j*PW +: PW] = in_dat[(2*j)*PW +: PW] + in_dat[(2*j+1)*PW +: PW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_dat   <= '0;
      out_valid <= 1'b0;
    end else if (ena) begin
      out_dat   <= sum;
      out_valid <= in_valid;
    end
  end

endmodule

// File: rtl/mul_add_tree.sv
// Pipelined unsigned multiplier: operand register, partial products, balanced adder tree.
// Latency LAT = log2(WIDTH)+1 enabled cycles; one pair per enabled cycle, no backpressure.
// ena=0 freezes every stage; rst_n clears all stages and the valid chain asynchronously.
module mul_add_tree
  import mul_add_tree_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     mul_a,
  input  logic [WIDTH-1:0]     mul_b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 out_valid
);

  localparam int LAT    = calc_lat(WIDTH);
  localparam int LEVELS = LAT - 1;
  localparam int PW     = 2 * WIDTH;
  localparam int NODES  = 2 * WIDTH - 1;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      vld_q <= 1'b0;
    end else if (ena) begin
      a_q   <= mul_a;
      b_q   <= mul_b;
      vld_q <= in_valid;
    end
  end

  logic [WIDTH*PW-1:0] pp;

  always_comb begin
    pp = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (b_q[i]) pp[i*PW +: PW] = PW'(a_q) << i;
    end
  end

  // Tree nodes stored level after level: WIDTH leaves, then WIDTH/2 sums, ..., one root.
  logic [NODES*PW-1:0] node;
  logic [LEVELS:0]     lvl_vld;

  assign node[WIDTH*PW-1:0] = pp;
  assign lvl_vld[0]         = vld_q;

  for (genvar l = 1; l <= LEVELS; l++) begin : g_level
    localparam int N_IN    = WIDTH >> (l - 1);
    localparam int IN_OFF  = 2 * WIDTH - 2 * N_IN;
    localparam int OUT_OFF = IN_OFF + N_IN;

    mul_add_tree_level #(
      .N_IN  (N_IN),
      .WIDTH (WIDTH)
    ) u_level (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .in_valid  (lvl_vld[l-1]),
      .in_dat    (node[IN_OFF*PW +: N_IN*PW]),
      .out_valid (lvl_vld[l]),
      .out_dat   (node[OUT_OFF*PW +: (N_IN/2)*PW])
    );
  end

  assign product   = node[(NODES-1)*PW +: PW];
  assign out_valid = lvl_vld[LEVELS];

endmodule

// File: tb/tb_mul_add_tree.sv
// Directed bench for mul_add_tree (WIDTH=4): latency model keyed on enabled-cycle count,
// checked every cycle, plus hand-computed literal checkpoints.
module tb_mul_add_tree;

  localparam int W   = 4;
  localparam int LAT = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           ena;
  logic           in_valid;
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic [2*W-1:0] product;
  logic           out_valid;

  int checks   = 0;
  int failures = 0;
  int vld_cnt  = 0;

  mul_add_tree #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_valid  (in_valid),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .product   (product),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: every accepted (enabled) cycle is logged; the result of log entry k
  // must be on the outputs once k+LAT enabled edges have occurred since reset.
  logic hist_v [0:4095];
  int   hist_p [0:4095];
  int   ecnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ecnt = 0;
    end else if (ena) begin
      hist_v[ecnt] = in_valid;
      hist_p[ecnt] = int'(mul_a) * int'(mul_b);
      ecnt = ecnt + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_product", int'(product), 0);
    end else begin
      if (ecnt >= LAT && hist_v[ecnt-LAT]) begin
        check("model_out_valid", int'(out_valid), 1);
        check("model_product", int'(product), hist_p[ecnt-LAT]);
      end else begin
        check("model_out_valid", int'(out_valid), 0);
      end
      if (out_valid === 1'b1) vld_cnt++;
    end
  end

  task automatic drive(input logic v, input int a, input int b, input logic e);
    in_valid = v;
    mul_a    = W'(a);
    mul_b    = W'(b);
    ena      = e;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 0, 0, 1'b1);
  endtask

  task automatic lit(input string name, input int exp_v, input int exp_p);
    check({name, "_valid"}, int'(out_valid), exp_v);
    if (exp_v == 1) check({name, "_product"}, int'(product), exp_p);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; mul_a = '0; mul_b = '0;
    #1;
    lit("por", 0, 0);
    check("por_product", int'(product), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Squares 0..9 streamed back to back.
    for (int i = 0; i <= 9; i++) begin
      drive(1'b1, i, i, 1'b1);
      if (i == 2) lit("sq0", 1, 0);
      if (i == 3) lit("sq1", 1, 1);
      if (i == 4) lit("sq2", 1, 4);
    end
    idle(1);
    lit("sq8", 1, 64);
    idle(1);
    lit("sq9", 1, 81);
    idle(1);
    lit("sq_done", 0, 0);

    // Corner operands.
    drive(1'b1, 15, 15, 1'b1);
    drive(1'b1, 15, 0, 1'b1);
    drive(1'b1, 0, 15, 1'b1);
    lit("max_sq", 1, 225);
    idle(1);
    lit("max_zero_b", 1, 0);
    idle(1);
    lit("max_zero_a", 1, 0);
    idle(3);

    // Exhaustive sweep.
    vld_cnt = 0;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        drive(1'b1, a, b, 1'b1);
    idle(3);
    check("sweep_valid_count", vld_cnt, 256);

    // Stall mid-flight; inputs offered while stalled must be ignored.
    drive(1'b1, 7, 6, 1'b1);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 3, 3, 1'b0);
      lit("stall_hold", 0, 0);
    end
    idle(1);
    lit("stall_pre", 0, 0);
    idle(1);
    lit("stall_42", 1, 42);
    idle(1);
    lit("stall_after", 0, 0);

    // Async reset with work in flight.
    drive(1'b1, 8, 8, 1'b1);
    drive(1'b1, 9, 9, 1'b1);
    drive(1'b1, 2, 2, 1'b1);
    lit("pre_rst_64", 1, 64);
    drive(1'b1, 3, 3, 1'b1);
    lit("pre_rst_81", 1, 81);
    mul_a = 4'd4; mul_b = 4'd4; in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", int'(out_valid), 0);
    check("async_rst_product", int'(product), 0);
    in_valid = 1'b0; mul_a = '0; mul_b = '0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < LAT + 2; k++) begin
      idle(1);
      lit("post_rst_quiet", 0, 0);
    end

    // Alternating valid.
    drive(1'b1, 2, 3, 1'b1);
    drive(1'b0, 0, 0, 1'b1);
    drive(1'b1, 5, 5, 1'b1);
    lit("alt_6", 1, 6);
    idle(1);
    lit("alt_gap", 0, 0);
    idle(1);
    lit("alt_25", 1, 25);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_add_tree.md
MUL_ADD_TREE -- requirements
Module: mul_add_tree

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; SHALL be a power of two, 2..16.
REQ-002 Derived constant LAT = log2(WIDTH)+1, pipeline latency in cycles; SHALL be 3 for the default WIDTH.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port ena, input, 1 bit: pipeline advance enable; while low, all pipeline state SHALL hold.
REQ-006 Port in_valid, input, 1 bit: mul_a/mul_b carry a new operand pair this cycle.
REQ-007 Port mul_a, input, WIDTH bits: unsigned multiplicand.
REQ-008 Port mul_b, input, WIDTH bits: unsigned multiplier.
REQ-009 Port product, output, 2*WIDTH bits: registered unsigned product.
REQ-010 Port out_valid, output, 1 bit: product holds the result of a valid operand pair.

Function
REQ-011 Partial products SHALL be pp[i] = mul_b[i] ? (mul_a << i) : 0, each zero-extended to 2*WIDTH bits.
REQ-012 Partial products SHALL be summed in a balanced binary tree: level 1 pairs (pp0+pp1, pp2+pp3, ...), each later level pairs the previous sums, with log2(WIDTH) levels in total.
REQ-013 All adders SHALL be 2*WIDTH bits wide; the true product never exceeds this width, so no overflow occurs.
REQ-014 Pipeline: stage 0 registers mul_a, mul_b and in_valid; each tree level registers its sums; the last level drives product.
REQ-015 An operand pair presented with in_valid=1 on cycle N with ena=1 SHALL appear on product with out_valid=1 after LAT enabled cycles.
REQ-016 A valid bit SHALL travel with the data through every stage; out_valid SHALL be the valid bit of the final stage.
REQ-017 Throughput SHALL be one operand pair per enabled cycle, with no back-pressure.
REQ-018 A stage holding an invalid entry SHALL still capture data, but out_valid=0 marks it; product is don't-care when out_valid=0.
REQ-019 When ena=0, product, out_valid and every stage register SHALL hold; inputs on that cycle SHALL be ignored.
REQ-020 Result SHALL equal mul_a*mul_b exactly for all 2^(2*WIDTH) input combinations.

Reset
REQ-021 Asserting rst_n low SHALL immediately clear every pipeline register, product (to 0) and out_valid (to 0), independent of clk and ena.
REQ-022 A reset asserted mid-operation SHALL discard all in-flight results; no stale out_valid SHALL follow deassertion.
REQ-023 The first operand pair accepted after rst_n rises SHALL appear LAT enabled cycles later.

Structure
REQ-024 Package mul_add_tree_pkg SHALL hold the default WIDTH and a function computing LAT from WIDTH.
REQ-025 One sub-module, mul_add_tree_level, SHALL implement a single registered tree level, parameterised by input count and WIDTH, with a valid pass-through.
REQ-026 The top SHALL instantiate log2(WIDTH) levels via generate, after the stage-0 operand register.

Verification
REQ-027 Hold ena=1 and in_valid=1, starting from a=b=0, and increment both every cycle up to 9 -> products 0,1,4,9,...,81 appear in order, starting 3 cycles after the first input.
REQ-028 Apply a=15, b=15, then a=15, b=0, then a=0, b=15 -> product is 225, 0, 0 on consecutive cycles.
REQ-029 Run an exhaustive 16x16 sweep, back-to-back -> every product matches a*b and out_valid is 1 on all 256 result cycles.
REQ-030 Input 7*6, then drive ena=0 for 5 cycles mid-flight -> product and out_valid frozen; 42 emerges after 3 enabled cycles in total.
REQ-031 Send 3 valid pairs, then pulse rst_n low asynchronously mid-cycle -> product=0 and out_valid=0 immediately; no results from those pairs ever appear.
REQ-032 Alternate in_valid 1/0 with inputs 2*3 and 5*5 -> out_valid pattern 1,0,1 with products 6 and 25.
